// File: rtl/dig_scan_driver_pkg.sv
// Shared constants for the 7-segment display peripherals: blanking codes,
// the hex-to-segment table and the bus address of the digit register.
package dig_scan_driver_pkg;

  localparam logic [7:0]  SEG_BLANK     = 8'hFF;
  localparam logic [7:0]  DIG_ALL_OFF   = 8'hFF;
  localparam logic [31:0] PERI_ADDR_DIG = 32'h1000_0010;

  // Active-low {dp,g,f,e,d,c,b,a}; entry 15 first, entry 0 last.
  localparam logic [15:0][7:0] HEX_SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/dig_scan_driver_hex7seg_decode.sv
// Combinational hex nibble to active-low 7-segment pattern (dp always off).
module hex7seg_decode
  import dig_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/dig_scan_driver.sv
// 8-digit multiplexed 7-segment driver with a write-only 32-bit data register.
// Optional leading-zero blanking is enabled by defining DIG_LEADING_ZERO_BLANK_EN.
module dig_scan_driver
  import dig_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV   = 20000,
  parameter int NUM_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [31:0]      data_reg;
  logic [CNT_W-1:0] scan_cnt;
  logic [IDX_W-1:0] idx;
  logic [7:0]       dig_en_reg;
  logic [7:0]       seg_reg;

  logic             dead;
  logic [7:0]       dec_seg;
  logic [7:0]       lit_seg;

  assign dead = (scan_cnt == CNT_W'(SCAN_DIV - 1));

  hex7seg_decode u_decode (
    .nibble (data_reg[4*idx +: 4]),
    .seg    (dec_seg)
  );

`ifdef DIG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] nz;
  logic [IDX_W-1:0]      top_idx;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nz
    assign nz[gi] = |data_reg[4*gi +: 4];
  end

  // Highest nonzero nibble; an all-zero word leaves digit 0 as the top.
  always_comb begin
    top_idx = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (nz[i]) top_idx = IDX_W'(i);
    end
  end

  assign lit_seg = (idx > top_idx) ? SEG_BLANK : dec_seg;
`else
  assign lit_seg = dec_seg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg   <= '0;
      scan_cnt   <= '0;
      idx        <= '0;
      dig_en_reg <= DIG_ALL_OFF;
      seg_reg    <= SEG_BLANK;
    end else begin
      if (we) data_reg <= wdata;

      if (dead) begin
        scan_cnt <= '0;
        idx      <= idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      // One dark cycle per slot so the old pattern never ghosts onto the next digit.
      if (dead) begin
        dig_en_reg <= DIG_ALL_OFF;
        seg_reg    <= SEG_BLANK;
      end else begin
        dig_en_reg <= ~(8'(1) << idx);
        seg_reg    <= lit_seg;
      end
    end
  end

  assign dig_en = dig_en_reg;
  assign seg    = seg_reg;

endmodule

// File: tb/tb_dig_scan_driver.sv
// Directed bench for dig_scan_driver with SCAN_DIV=4 (one frame = 32 cycles).
module tb_dig_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] wdata;
  logic [7:0]  dig_en;
  logic [7:0]  seg;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        we;
    logic [31:0] wdata;
    logic [7:0]  dig;
    logic [7:0]  seg;
  } vec_t;

  vec_t frame_tbl[32];
  logic [7:0] pair_dig[8];
  logic [7:0] pair_seg[8];
  logic [7:0] exp_hi;

  dig_scan_driver #(.SCAN_DIV(4), .NUM_DIGITS(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .wdata  (wdata),
    .dig_en (dig_en),
    .seg    (seg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [7:0] exp_dig, input logic [7:0] exp_seg);
    tests++;
    if (dig_en !== exp_dig || seg !== exp_seg) begin
      fails++;
      $display("FAIL %s: got dig_en=%h seg=%h, expected dig_en=%h seg=%h",
               name, dig_en, seg, exp_dig, exp_seg);
    end else begin
      $display("ok   %s: dig_en=%h seg=%h", name, dig_en, seg);
    end
  endtask

  initial begin
    // Expected frame for 32'h12345678, digit 0..7 lit for 3 cycles then dark.
    pair_dig = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    pair_seg = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    for (int j = 0; j < 32; j++) begin
      frame_tbl[j].we    = 1'b0;
      frame_tbl[j].wdata = 32'h0;
      frame_tbl[j].dig   = (j % 4 == 3) ? 8'hFF : pair_dig[j / 4];
      frame_tbl[j].seg   = (j % 4 == 3) ? 8'hFF : pair_seg[j / 4];
    end

`ifdef DIG_LEADING_ZERO_BLANK_EN
    exp_hi = 8'hFF;
`else
    exp_hi = 8'hC0;
`endif

    rst = 1'b1; we = 1'b0; wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_hold%0d", i), 8'hFF, 8'hFF);
    end
    rst = 1'b0;
    tick();                                            // e1
    check("first_after_reset", 8'hFE, 8'hC0);

    we = 1'b1; wdata = 32'h1234_5678;
    tick();                                            // e2: write
    we = 1'b0;
    tick();                                            // e3
    check("write_latency", 8'hFE, 8'h80);
    ticks(29);                                         // through e32

    for (int j = 0; j < 32; j++) begin                 // e33..e64
      we = frame_tbl[j].we; wdata = frame_tbl[j].wdata;
      tick();
      check($sformatf("frame_slot%0d", j), frame_tbl[j].dig, frame_tbl[j].seg);
    end

    ticks(8);                                          // e65..e72
    we = 1'b1; wdata = 32'hFFFF_FFFF;
    tick();                                            // e73: digit 2 lit, write
    we = 1'b0;
    check("write_mid_digit_old", 8'hFB, 8'h82);
    tick();                                            // e74
    check("write_mid_digit_new", 8'hFB, 8'h8E);

    ticks(5);                                          // e75..e79
    we = 1'b1; wdata = 32'h0000_ABCD;
    tick();                                            // e80: dead + advance + write
    we = 1'b0;
    check("advance_write_dead", 8'hFF, 8'hFF);
    tick();                                            // e81
    check("advance_write_digit4", 8'hEF, exp_hi);
    ticks(15);                                         // through e96

    pair_seg = '{8'hA1, 8'hC6, 8'h83, 8'h88, exp_hi, exp_hi, exp_hi, exp_hi};
    for (int d = 0; d < 8; d++) begin                  // e97..e128
      tick();
      check($sformatf("abcd_digit%0d", d), pair_dig[d], pair_seg[d]);
      ticks(3);
    end

    we = 1'b1; wdata = 32'h0;
    tick();                                            // e129: write 0
    we = 1'b0;
    ticks(31);                                         // through e160
    for (int d = 0; d < 8; d++) begin                  // e161..e192
      tick();
      check($sformatf("zero_digit%0d", d), pair_dig[d], (d == 0) ? 8'hC0 : exp_hi);
      ticks(3);
    end

    we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();                                            // e193
    we = 1'b0;
    ticks(19);                                         // through e212
    tick();                                            // e213: digit 5 lit
    check("deadbeef_digit5", 8'hDF, 8'h88);
    rst = 1'b1;
    tick();                                            // e214
    check("mid_frame_reset", 8'hFF, 8'hFF);
    rst = 1'b0;
    tick();                                            // e215
    check("restart_digit0", 8'hFE, 8'hC0);
    ticks(3);
    tick();                                            // e219: digit 1
    check("restart_digit1", 8'hFD, exp_hi);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dig_scan_driver.md
Name: dig_scan_driver

Overview:
- Memory-mapped 8-digit, 7-segment display peripheral; the responder on the bus bridge's digit-write path.
- Bridge drives `we`/`wdata` when the CPU stores to the DIG address; this block latches the 32-bit word.
- Scans eight hex digits (one nibble each) onto a shared active-low segment bus with per-digit active-low enables.
- Write-only: no read path.

Parameters:
- SCAN_DIV, 20000, clock cycles per digit slot including one dead cycle; legal range >= 2.
- NUM_DIGITS, 8, fixed at 8; present for documentation only, other values unsupported.

Ports:
- clk  input  1  system clock, single clock domain
- rst  input  1  synchronous reset, active-high
- we  input  1  write strobe, already qualified by address decode in the bridge
- wdata  input  32  display word; nibble i goes to digit i (digit 0 = rightmost)
- dig_en  output  8  digit enables, active-low; bit i = digit i
- seg  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}

Behaviour:
- State: data_reg[31:0], scan_cnt (clog2(SCAN_DIV) bits), idx[2:0], registered dig_en and seg.
- Reset (rst=1 at a rising edge): data_reg=0, scan_cnt=0, idx=0, dig_en=8'hFF, seg=8'hFF. Reset overrides `we` in the same cycle.
- Write: `we`=1 at an edge loads data_reg<=wdata. Back-to-back writes are allowed; the last one wins.
- Scan counter: every non-reset edge:
  - scan_cnt==SCAN_DIV-1: scan_cnt<=0, idx<=idx+1 (7 wraps to 0).
  - Otherwise: scan_cnt<=scan_cnt+1.
- Output register, every non-reset edge:
  - Dead cycle (scan_cnt==SCAN_DIV-1): dig_en<=8'hFF and seg<=8'hFF, for anti-ghosting.
  - Otherwise: dig_en<=~(8'b1<<idx) and seg<=hex(data_reg[4*idx+:4]).
- Timing consequences:
  - Each digit is lit for SCAN_DIV-1 cycles, then dark for 1 cycle.
  - One frame = 8*SCAN_DIV cycles.
  - First edge after reset release gives dig_en=8'hFE.
- Latency: a write at edge k updates data_reg at k; seg reflects it at edge k+1 if that digit is being scanned. Exactly one dig_en bit is low outside dead cycles.
- Simultaneous write and digit advance: both apply. The next lit cycle shows the new idx with the new data.
- Hex decode (active-low, dp always 1): 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.
- Reset mid-frame: scan restarts at digit 0 and data_reg clears. No partial state survives.

Optional Feature:
- Macro: DIG_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit i is blanked (seg=8'hFF, dig_en still asserted per scan) when i > m, where m = index of the highest nonzero nibble of data_reg.
  - data_reg==0 shows only digit 0 as "0".
  - m is computed combinationally from data_reg; no extra latency.
- Undefined: all eight digits always show their hex value, including leading zeros.

Decomposition:
- Shared package/defines:
  - SEG_BLANK = 8'hFF
  - DIG_ALL_OFF = 8'hFF
  - the 16-entry hex-to-segment constant table
  - PERI_ADDR_DIG, already in the common defines
- Sub-module: hex7seg_decode, purely combinational, 4-bit in, 8-bit active-low out. It is used by this block and reusable by other display logic.

Test Plan (SCAN_DIV=4 in bench):
- Reset held 3 cycles, then released -> during reset dig_en=FF and seg=FF; first edge after release dig_en=FE, seg=C0.
- Write 32'h12345678 -> over one frame (32 cycles), observe pairs in order digit0..7: (FE,80)(FD,F8)(FB,82)(F7,92)(EF,99)(DF,B0)(BF,A4)(7F,F9). Each pair lasts 3 cycles, followed by 1 cycle of FF/FF.
- Write 32'hFFFFFFFF while digit 2 is lit -> next edge seg=8E with dig_en=FB. No dead cycle is inserted by the write.
- Write 32'h0000ABCD at the same edge as the digit 3->4 advance:
  - Without the macro: the next lit cycle shows dig_en=EF, seg=C0.
  - With DIG_LEADING_ZERO_BLANK_EN: dig_en=EF, seg=FF, and digits 0..3 show A1,C6,83,88.
- With the macro, write 0 -> digit 0 shows C0 and digits 1..7 show FF.
- Assert rst while digit 5 is lit with data 32'hDEADBEEF -> next edge dig_en=FF, seg=FF. After release the scan restarts at digit 0 with seg=C0, and the previous data is gone.
